run_monitor: RTL

Synthesizable run-control monitor for the pipelined RV32 core: watches the committed PC stream, counts cycles and retired instructions, and halts the run when the PC hits any of several programmable stop addresses, a cycle budget expires, or the pipeline stops retiring. It sits beside the CPU top level and drives a single `done` strobe plus latched halt status, so every test program ends the same way in simulation and on the FPGA.

---
 rtl/run_monitor_pkg.sv | 22 ++
 rtl/stop_match.sv | 45 ++++
 rtl/run_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types for the run-control monitor.
//   state_t  - monitor FSM states (IDLE / RUN / HALT)
//   cause_t  - halt cause codes reported on halt_cause
//   CAUSE_W  - width of the halt cause field
package run_monitor_pkg;

    localparam int CAUSE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_STOP    = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_STALL   = 2'd3
    } cause_t;

endpackage

// File: rtl/stop_match.sv
// stop_match: NUM_STOP parallel stop-address comparators with a
// lowest-index-wins priority encoder.
// Ports:
//   pc        in  XLEN           committed PC this cycle
//   pc_valid  in  1              pc is a real commit
//   stop_addr in  NUM_STOP*XLEN  entry i at [i*XLEN +: XLEN]
//   stop_en   in  NUM_STOP       per-entry enable
//   hit       out 1              some enabled entry matches a valid commit
//   idx       out IDX_W          lowest matching entry (0 when no hit)
module stop_match #(
    parameter int XLEN     = 32,
    parameter int NUM_STOP = 4,
    parameter int IDX_W    = 2
) (
    input  logic [XLEN-1:0]          pc,
    input  logic                     pc_valid,
    input  logic [NUM_STOP*XLEN-1:0] stop_addr,
    input  logic [NUM_STOP-1:0]      stop_en,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx
);

    logic [NUM_STOP-1:0] match;

    for (genvar g = 0; g < NUM_STOP; g++) begin : g_cmp
        assign match[g] = pc_valid && stop_en[g] &&
                          (pc == stop_addr[g*XLEN +: XLEN]);
    end

    // Walk the match vector from bit 0 upward; the first set bit wins.
    always_comb begin
        logic [NUM_STOP-1:0] rest;
        hit  = 1'b0;
        idx  = '0;
        rest = match;
        for (int unsigned i = 0; i < NUM_STOP; i++) begin
            if (!hit && rest[0]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
            rest = rest >> 1;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run-control monitor for the pipelined RV32 core. Counts RUN
// cycles and retired instructions, and halts on a stop-address hit, a cycle
// budget expiry, or (optionally) a retire stall.
// Optional feature: define RUN_MONITOR_STALL_EN to build the stall detector.
// Ports:
//   clk, reset    in  1              rising-edge clock, sync active-high reset
//   start         in  1              pulse: IDLE/HALT -> RUN (ignored in RUN)
//   pc, pc_valid  in  XLEN, 1        committed PC stream
//   stop_addr     in  NUM_STOP*XLEN  stop addresses (sampled live)
//   stop_en       in  NUM_STOP       per-entry enables (sampled live)
//   done          out 1              one-cycle pulse on entry to HALT
//   halted        out 1              high while in HALT
//   halt_cause    out 2              0 NONE, 1 STOP, 2 TIMEOUT, 3 STALL
//   halt_idx      out IDX_W          matching stop entry
//   halt_pc       out XLEN           last valid committed PC at halt
//   cycle_count   out CNT_W          cycles spent in RUN (saturating)
//   retire_count  out CNT_W          valid commits in RUN (saturating)
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_STOP    = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 100000,
    parameter int STALL_LIMIT = 256,
    localparam int IDX_W      = (NUM_STOP > 1) ? $clog2(NUM_STOP) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [XLEN-1:0]          pc,
    input  logic                     pc_valid,
    input  logic [NUM_STOP*XLEN-1:0] stop_addr,
    input  logic [NUM_STOP-1:0]      stop_en,
    output logic                     done,
    output logic                     halted,
    output logic [CAUSE_W-1:0]       halt_cause,
    output logic [IDX_W-1:0]         halt_idx,
    output logic [XLEN-1:0]          halt_pc,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retire_count
);

    state_t            state, state_nxt;
    cause_t            cause_r, cause_nxt;
    logic              arm, halt_ev;
    logic              hit, timeout_hit, stall_hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [XLEN-1:0]   last_pc;

    stop_match #(
        .XLEN     (XLEN),
        .NUM_STOP (NUM_STOP),
        .IDX_W    (IDX_W)
    ) u_stop_match (
        .pc        (pc),
        .pc_valid  (pc_valid),
        .stop_addr (stop_addr),
        .stop_en   (stop_en),
        .hit       (hit),
        .idx       (hit_idx)
    );

    // cycle_count is the pre-increment value, so matching BUDGET-1 halts
    // with the count reading exactly BUDGET alongside done.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cycle_count == TO_LAST);

`ifdef RUN_MONITOR_STALL_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || arm || pc_valid) stall_cnt <= '0;
        else if (state == RUN)        stall_cnt <= stall_cnt + 1'b1;
    end

    // Halts on the idle cycle that brings the run of idle cycles to the limit.
    assign stall_hit = !pc_valid && (stall_cnt == STALL_LAST);
`else
    // No stall detector in this build; the parameter is still accepted so
    // instantiations are identical across builds.
    assign stall_hit = 1'b0 & (STALL_LIMIT != 0);
`endif

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        halt_ev   = 1'b0;
        cause_nxt = CAUSE_NONE;
        if (hit)              cause_nxt = CAUSE_STOP;
        else if (timeout_hit) cause_nxt = CAUSE_TIMEOUT;
        else if (stall_hit)   cause_nxt = CAUSE_STALL;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    arm       = 1'b1;
                end
            end
            RUN: begin
                if (cause_nxt != CAUSE_NONE) begin
                    state_nxt = HALT;
                    halt_ev   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            cause_r      <= CAUSE_NONE;
            halt_idx     <= '0;
            halt_pc      <= '0;
            last_pc      <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;
            done  <= halt_ev;
            if (arm) begin
                cycle_count  <= '0;
                retire_count <= '0;
                cause_r      <= CAUSE_NONE;
                halt_idx     <= '0;
            end else if (state == RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                if (pc_valid) begin
                    if (retire_count != '1) retire_count <= retire_count + 1'b1;
                    last_pc <= pc;
                end
                if (halt_ev) begin
                    cause_r  <= cause_nxt;
                    halt_idx <= hit_idx;
                    halt_pc  <= pc_valid ? pc : last_pc;
                end
            end
        end
    end

    assign halted     = (state == HALT);
    assign halt_cause = cause_r;

endmodule
